// File: rtl/serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and helpers for the serial frame transmitter.
//   tx_state_t   : transmitter FSM states
//   frame_cycles : clock cycles from the accepting edge back to IDLE
// ---------------------------------------------------------------------------
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Start bit + data bits + optional parity bit + stop bit, each held
    // clks_per_bit cycles.
    function automatic int frame_cycles(input int data_w,
                                        input int clks_per_bit,
                                        input int parity_en);
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Free-running bit-period counter. tick pulses on the last cycle of each
// serial bit; clr restarts the period so a frame's start bit gets a full
// CLKS_PER_BIT cycles.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : synchronous reset, active-low
//   clr   : restart the bit period (handshake edge)
//   tick  : last cycle of the current bit period
// ---------------------------------------------------------------------------
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    // At least one bit wide so CLKS_PER_BIT=1 still elaborates; in that case
    // the counter sits at 0 and tick is permanently high.
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
// Parallel-in, serial-out frame transmitter. Accepts a DATA_W-bit word on a
// valid/ready handshake and sends start(0), data LSB first, optional even
// parity, stop(1), each bit held CLKS_PER_BIT cycles.
// Ports:
//   CLK       : rising-edge clock
//   RST_N     : synchronous reset, active-low
//   DIN       : word to transmit, sampled on the handshake edge
//   DIN_VALID : DIN holds a word to send
//   DIN_READY : transmitter idle (combinational from state)
//   Q         : serial line, idle high, registered
//   BUSY      : frame in progress, registered
// ---------------------------------------------------------------------------
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              Q,
    output logic              BUSY
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              par_q, par_d;
    logic              q_q, q_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              tick;
    logic [DATA_W-1:0] shr;

    assign DIN_READY = (state_q == IDLE);
    assign accept    = DIN_VALID && DIN_READY;
    assign shr       = shreg_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        q_d      = q_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = DIN;
                    // Parity is captured up front since the shift register
                    // is consumed by the time the parity bit goes out.
                    par_d    = ^DIN;
                    bitcnt_d = '0;
                    state_d  = START;
                    q_d      = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    q_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d  = shr;
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            q_d     = par_q;
                        end else begin
                            state_d = STOP;
                            q_d     = 1'b1;
                        end
                    end else begin
                        q_d = shr[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    q_d     = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            q_q      <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
        end
    end

    assign Q    = q_q;
    assign BUSY = busy_q;

endmodule
